life_engine_rs: RTL and testbench

- Parametrised next-generation Game of Life datapath for a ROWS x COLS grid.
- Adds configurable boundary mode (dead edge or torus) and a configurable birth/survive rule.
- Computes a generation row-serially, one row per cycle, with a step handshake, a generation counter, and stable/extinct flags.
- Sits between the control FSM (supplies state, program strobes, step requests) and the display/LED driver (consumes grid).

---
 rtl/life_pkg.sv | 28 ++
 rtl/life_engine_rs_if.sv | 43 ++++
 rtl/life_row_eval.sv | 36 +++
 rtl/life_engine_rs.sv | 152 +++++++++++++++
 tb/tb_life_engine_rs.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/life_pkg.sv
// Shared encodings, sweep FSM states, default rule masks and small helpers
// for the row-serial Game of Life engine.
package life_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_PROGRAM = 2'b01;
    localparam logic [1:0] ST_RUN     = 2'b10;
    localparam logic [1:0] ST_PAUSE   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SWEEP  = 2'd1,
        S_COMMIT = 2'd2
    } sweep_t;

    // Bit n of a mask applies to a cell with n live neighbours.
    localparam logic [8:0] RULE_B3  = 9'b000001000;
    localparam logic [8:0] RULE_S23 = 9'b000001100;

    function automatic int idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

    function automatic logic [3:0] pop3(input logic [2:0] v);
        return 4'(v[0]) + 4'(v[1]) + 4'(v[2]);
    endfunction

endpackage

// File: rtl/life_engine_rs_if.sv
// Control/display bundle of the Life engine; the control FSM side is master,
// the engine is slave.
interface life_engine_rs_if #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int GEN_W = 16
);
    import life_pkg::*;

    localparam int N  = ROWS * COLS;
    localparam int IW = $clog2(N);
    localparam int RW = $clog2(ROWS);

    // Step handshake: step_req is valid, (state==RUN && !busy) is ready; a
    // generation starts on the rising clock edge where both hold. step_req is
    // not queued, so a request that sees ready low is simply dropped.
    logic [1:0]       state;
    logic             prog_valid;
    logic             prog_bit;
    logic             step_req;
    logic [N-1:0]     grid;
    logic [IW-1:0]    prog_idx;
    logic             busy;
    logic             gen_done;
    logic [GEN_W-1:0] gen_count;
    logic             stable;
    logic             extinct;
    sweep_t           dbg_fsm;
    logic [RW-1:0]    dbg_row;

    modport master (
        output state, prog_valid, prog_bit, step_req,
        input  grid, prog_idx, busy, gen_done, gen_count, stable, extinct,
               dbg_fsm, dbg_row
    );

    modport slave (
        input  state, prog_valid, prog_bit, step_req,
        output grid, prog_idx, busy, gen_done, gen_count, stable, extinct,
               dbg_fsm, dbg_row
    );

endinterface

// File: rtl/life_row_eval.sv
// Combinational next-state of one grid row from the rows above, at and below it.
module life_row_eval import life_pkg::*; #(
    parameter int         COLS    = 8,
    parameter int         WRAP    = 0,
    parameter logic [8:0] BIRTH   = RULE_B3,
    parameter logic [8:0] SURVIVE = RULE_S23
) (
    input  logic [COLS-1:0] up_i,
    input  logic [COLS-1:0] mid_i,
    input  logic [COLS-1:0] dn_i,
    output logic [COLS-1:0] row_o
);

    // Widened so any 4-bit count indexes in range; counts above 8 cannot occur.
    localparam logic [15:0] BIRTH_M   = {7'd0, BIRTH};
    localparam logic [15:0] SURVIVE_M = {7'd0, SURVIVE};

    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int CL    = (c == 0) ? COLS - 1 : c - 1;
        localparam int CR    = (c == COLS - 1) ? 0 : c + 1;
        localparam bit HAS_L = (c != 0) || (WRAP != 0);
        localparam bit HAS_R = (c != COLS - 1) || (WRAP != 0);

        logic [2:0] lft;
        logic [2:0] ctr;
        logic [2:0] rgt;
        logic [3:0] n;

        assign lft   = HAS_L ? {up_i[CL], mid_i[CL], dn_i[CL]} : 3'b000;
        assign ctr   = {up_i[c], 1'b0, dn_i[c]};
        assign rgt   = HAS_R ? {up_i[CR], mid_i[CR], dn_i[CR]} : 3'b000;
        assign n     = pop3(lft) + pop3(ctr) + pop3(rgt);
        assign row_o[c] = mid_i[c] ? SURVIVE_M[n] : BIRTH_M[n];
    end

endmodule

// File: rtl/life_engine_rs.sv
// Row-serial Game of Life engine: programmable grid, one row evaluated per
// cycle into a shadow buffer, then committed atomically.
module life_engine_rs import life_pkg::*; #(
    parameter int         ROWS    = 8,
    parameter int         COLS    = 8,
    parameter int         WRAP    = 0,
    parameter logic [8:0] BIRTH   = RULE_B3,
    parameter logic [8:0] SURVIVE = RULE_S23,
    parameter int         GEN_W   = 16
) (
    input  logic            clka,
    input  logic            stop,
    life_engine_rs_if.slave bus
);

    localparam int N  = ROWS * COLS;
    localparam int IW = $clog2(N);
    localparam int RW = $clog2(ROWS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    sweep_t           fsm_q, fsm_d;
    logic [RW-1:0]    row_q, row_d;
    logic [N-1:0]     grid_q;
    logic [N-1:0]     next_q;
    logic [IW-1:0]    prog_idx_q;
    logic [GEN_W-1:0] gen_count_q;
    logic             gen_done_q;
    logic             stable_q;
    logic             extinct_q;

    logic             accept;
    int               row_base;
    logic [COLS-1:0]  up_row;
    logic [COLS-1:0]  mid_row;
    logic [COLS-1:0]  dn_row;
    logic [COLS-1:0]  new_row;

    assign accept = (fsm_q == S_IDLE) && (bus.state == ST_RUN) && bus.step_req;

    always_ff @(posedge clka or posedge stop) begin
        if (stop) begin
            fsm_q <= S_IDLE;
            row_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            row_q <= row_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        row_d = row_q;
        case (fsm_q)
            S_IDLE: begin
                if (accept) begin
                    fsm_d = S_SWEEP;
                    row_d = '0;
                end
            end
            S_SWEEP: begin
                if (row_q == LAST_ROW) fsm_d = S_COMMIT;
                else                   row_d = row_q + RW'(1);
            end
            S_COMMIT: fsm_d = S_IDLE;
            default:  fsm_d = S_IDLE;
        endcase
    end

    // Neighbour rows for the row under evaluation; off-grid rows read as dead
    // unless the grid is a torus.
    always_comb begin
        row_base = idx(int'(row_q), 0, COLS);
        mid_row  = grid_q[row_base +: COLS];
        up_row   = '0;
        dn_row   = '0;
        if (row_q != '0)     up_row = grid_q[row_base - COLS +: COLS];
        else if (WRAP != 0)  up_row = grid_q[idx(ROWS - 1, 0, COLS) +: COLS];
        if (row_q != LAST_ROW) dn_row = grid_q[row_base + COLS +: COLS];
        else if (WRAP != 0)    dn_row = grid_q[0 +: COLS];
    end

    life_row_eval #(
        .COLS    (COLS),
        .WRAP    (WRAP),
        .BIRTH   (BIRTH),
        .SURVIVE (SURVIVE)
    ) u_row_eval (
        .up_i  (up_row),
        .mid_i (mid_row),
        .dn_i  (dn_row),
        .row_o (new_row)
    );

    // grid_q only changes outside a sweep, so every row of a generation sees
    // the same predecessor.
    always_ff @(posedge clka or posedge stop) begin
        if (stop) begin
            grid_q      <= '0;
            next_q      <= '0;
            prog_idx_q  <= '0;
            gen_count_q <= '0;
            gen_done_q  <= 1'b0;
            stable_q    <= 1'b0;
            extinct_q   <= 1'b0;
        end else begin
            gen_done_q <= 1'b0;
            case (fsm_q)
                S_SWEEP: next_q[row_base +: COLS] <= new_row;
                S_COMMIT: begin
                    grid_q     <= next_q;
                    gen_done_q <= 1'b1;
                    stable_q   <= (next_q == grid_q);
                    extinct_q  <= (next_q == '0);
                    if (gen_count_q != '1) gen_count_q <= gen_count_q + GEN_W'(1);
                end
                default: begin
                    case (bus.state)
                        ST_IDLE: begin
                            grid_q      <= '0;
                            next_q      <= '0;
                            prog_idx_q  <= '0;
                            gen_count_q <= '0;
                            stable_q    <= 1'b0;
                            extinct_q   <= 1'b0;
                        end
                        ST_PROGRAM: begin
                            if (bus.prog_valid) begin
                                grid_q[prog_idx_q] <= bus.prog_bit;
                                prog_idx_q <= (prog_idx_q == LAST_IDX) ? '0
                                                                       : prog_idx_q + IW'(1);
                            end
                        end
                        ST_RUN, ST_PAUSE: ;
                        default: ;
                    endcase
                end
            endcase
        end
    end

    assign bus.grid      = grid_q;
    assign bus.prog_idx  = prog_idx_q;
    assign bus.busy      = (fsm_q != S_IDLE);
    assign bus.gen_done  = gen_done_q;
    assign bus.gen_count = gen_count_q;
    assign bus.stable    = stable_q;
    assign bus.extinct   = extinct_q;
    assign bus.dbg_fsm   = fsm_q;
    assign bus.dbg_row   = row_q;

endmodule

// File: tb/tb_life_engine_rs.sv
// Bench for life_engine_rs: a dead-edge and a torus instance share one stimulus
// stream and are checked every cycle against a generation-level model.
module tb_life_engine_rs;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int N     = ROWS * COLS;
    localparam int GEN_W = 16;

    logic       clka = 1'b0;
    logic       stop = 1'b1;
    logic [1:0] state = 2'b00;
    logic       prog_valid = 1'b0;
    logic       prog_bit = 1'b0;
    logic       step_req = 1'b0;

    life_engine_rs_if #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W)) bus0 ();
    life_engine_rs_if #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W)) bus1 ();

    assign bus0.state = state;      assign bus1.state = state;
    assign bus0.prog_valid = prog_valid; assign bus1.prog_valid = prog_valid;
    assign bus0.prog_bit = prog_bit;  assign bus1.prog_bit = prog_bit;
    assign bus0.step_req = step_req;  assign bus1.step_req = step_req;

    life_engine_rs #(.ROWS(ROWS), .COLS(COLS), .WRAP(0), .BIRTH(9'b000001000),
                     .SURVIVE(9'b000001100), .GEN_W(GEN_W))
        dut0 (.clka(clka), .stop(stop), .bus(bus0.slave));

    life_engine_rs #(.ROWS(ROWS), .COLS(COLS), .WRAP(1), .BIRTH(9'b000001000),
                     .SURVIVE(9'b000001100), .GEN_W(GEN_W))
        dut1 (.clka(clka), .stop(stop), .bus(bus1.slave));

    // ---------------- clock / watchdog ----------------
    always #5 clka = ~clka;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / reference model ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [N-1:0] exp_q0[$];
    logic [N-1:0] exp_q1[$];
    logic [N-1:0] m_grid[2];
    bit           m_stable[2];
    bit           m_extinct[2];
    int           m_gen;
    int           m_idx;
    int           m_cnt;   // cycles until the pending generation appears

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] life_next(input logic [N-1:0] g, input bit wrap);
        logic [N-1:0] nx;
        int n, rr, cc;
        nx = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr == 0 && dc == 0) continue;
                        rr = r + dr;
                        cc = c + dc;
                        if (wrap) begin
                            rr = (rr + ROWS) % ROWS;
                            cc = (cc + COLS) % COLS;
                        end else if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) begin
                            continue;
                        end
                        n += int'(g[rr * COLS + cc]);
                    end
                end
                nx[r * COLS + c] = g[r * COLS + c] ? (n == 2 || n == 3) : (n == 3);
            end
        end
        return nx;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_grid[i] = '0;
            m_stable[i] = 1'b0;
            m_extinct[i] = 1'b0;
        end
        m_gen = 0;
        m_idx = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    // Advance one clock: update the model for this edge, then compare all outputs.
    task automatic cycle(input string tag);
        bit acc, commit;
        logic [N-1:0] nx;
        acc    = (state == 2'b10) && step_req && (m_cnt == 0);
        commit = (m_cnt == 1);
        if (commit) begin
            for (int i = 0; i < 2; i++) begin
                nx = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                m_stable[i]  = (nx == m_grid[i]);
                m_extinct[i] = (nx == '0);
                m_grid[i]    = nx;
            end
            if (m_gen != 65535) m_gen++;
        end else if (m_cnt == 0) begin
            if (state == 2'b00) begin
                model_clear();
            end else if (state == 2'b01 && prog_valid) begin
                m_grid[0][m_idx] = prog_bit;
                m_grid[1][m_idx] = prog_bit;
                m_idx = (m_idx + 1) % N;
            end
        end
        if (acc) begin
            exp_q0.push_back(life_next(m_grid[0], 1'b0));
            exp_q1.push_back(life_next(m_grid[1], 1'b1));
        end
        tick();
        if (acc) m_cnt = ROWS + 1;
        else if (m_cnt > 0) m_cnt--;

        check($sformatf("%s grid_w0", tag), bus0.grid, m_grid[0]);
        check($sformatf("%s grid_w1", tag), bus1.grid, m_grid[1]);
        check($sformatf("%s busy_w0", tag), bus0.busy, m_cnt > 0);
        check($sformatf("%s busy_w1", tag), bus1.busy, m_cnt > 0);
        check($sformatf("%s gen_done_w0", tag), bus0.gen_done, commit);
        check($sformatf("%s gen_done_w1", tag), bus1.gen_done, commit);
        check($sformatf("%s gen_count_w0", tag), bus0.gen_count, m_gen);
        check($sformatf("%s gen_count_w1", tag), bus1.gen_count, m_gen);
        check($sformatf("%s stable_w0", tag), bus0.stable, m_stable[0]);
        check($sformatf("%s stable_w1", tag), bus1.stable, m_stable[1]);
        check($sformatf("%s extinct_w0", tag), bus0.extinct, m_extinct[0]);
        check($sformatf("%s extinct_w1", tag), bus1.extinct, m_extinct[1]);
        check($sformatf("%s prog_idx", tag), bus0.prog_idx, m_idx);
    endtask

    task automatic cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    task automatic do_reset(input string tag);
        stop = 1'b1;
        model_clear();
        m_cnt = 0;
        exp_q0.delete();
        exp_q1.delete();
        #2;
        check({tag, " grid_w0"}, bus0.grid, 64'd0);
        check({tag, " grid_w1"}, bus1.grid, 64'd0);
        check({tag, " busy"}, bus0.busy, 1'b0);
        check({tag, " gen_count"}, bus0.gen_count, 16'd0);
        check({tag, " prog_idx"}, bus0.prog_idx, 6'd0);
        check({tag, " gen_done"}, bus0.gen_done, 1'b0);
        check({tag, " stable"}, bus0.stable, 1'b0);
        check({tag, " extinct"}, bus0.extinct, 1'b0);
        tick();
        stop = 1'b0;
    endtask

    task automatic load(input logic [N-1:0] pat, input string tag);
        state = 2'b00;
        cycles(2, tag);
        state = 2'b01;
        for (int i = 0; i < N; i++) begin
            prog_valid = 1'b1;
            prog_bit   = pat[i];
            cycle(tag);
        end
        prog_valid = 1'b0;
        cycle(tag);
        check({tag, " loaded"}, bus0.grid, pat);
    endtask

    task automatic step_wait(input string tag);
        int lat;
        state    = 2'b10;
        step_req = 1'b1;
        cycle(tag);
        step_req = 1'b0;
        lat = 0;
        while (bus0.gen_done !== 1'b1 && lat < 40) begin
            cycle(tag);
            lat++;
        end
        check({tag, " latency"}, lat, ROWS + 1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [N-1:0] pat;
        int pulses, t0, t1;

        m_cnt = 0;
        do_reset("reset");

        // Blinker: horizontal -> vertical -> horizontal.
        load(64'h0000_0000_1C00_0000, "blinker");
        step_wait("blinker1");
        check("blinker1 shape", bus0.grid, 64'h0000_0008_0808_0000);
        step_wait("blinker2");
        check("blinker2 shape", bus0.grid, 64'h0000_0000_1C00_0000);
        check("blinker2 gen_count", bus0.gen_count, 16'd2);
        check("blinker2 stable", bus0.stable, 1'b0);

        // Block still life.
        load(64'h0000_0000_0006_0600, "block");
        step_wait("block");
        check("block shape", bus0.grid, 64'h0000_0000_0006_0600);
        check("block stable", bus0.stable, 1'b1);
        check("block extinct", bus0.extinct, 1'b0);

        // Corners: dies on a dead edge, forms a block across the torus seam.
        load(64'h0100_0000_0000_0081, "corners");
        step_wait("corners");
        check("corners w0 grid", bus0.grid, 64'd0);
        check("corners w0 extinct", bus0.extinct, 1'b1);
        check("corners w1 grid", bus1.grid, 64'h8100_0000_0000_0081);

        // Random soups, several generations each.
        for (int k = 0; k < 4; k++) begin
            pat = {$urandom(), $urandom()};
            load(pat, $sformatf("rand%0d", k));
            for (int s = 0; s < 3; s++) step_wait($sformatf("rand%0d_s%0d", k, s));
        end

        // Programming cursor wraps after the last cell.
        state = 2'b00;
        cycles(2, "pwrap");
        state = 2'b01;
        for (int i = 0; i <= N; i++) begin
            prog_valid = 1'b1;
            prog_bit   = (i < N);
            cycle("pwrap");
        end
        prog_valid = 1'b0;
        cycle("pwrap");
        check("pwrap prog_idx", bus0.prog_idx, 6'd1);
        check("pwrap grid", bus0.grid, ~64'd1);

        // Strobes outside PROGRAM are ignored.
        state = 2'b11;
        prog_valid = 1'b1;
        prog_bit = 1'b0;
        cycles(3, "prog_ignored");
        prog_valid = 1'b0;

        // Held request: two back-to-back generations in 20 cycles.
        load({$urandom(), $urandom()}, "hold");
        state = 2'b10;
        step_req = 1'b1;
        pulses = 0; t0 = 0; t1 = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle("hold");
            if (bus0.gen_done === 1'b1) begin
                if (pulses == 0) t0 = i; else t1 = i;
                pulses++;
            end
        end
        step_req = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cycle("hold_tail");
            if (bus0.gen_done === 1'b1) pulses++;
        end
        check("hold pulses", pulses, 2);
        check("hold spacing", t1 - t0, 10);

        // PAUSE mid-sweep: the running generation still commits, nothing more.
        step_req = 1'b1;
        cycle("pause");
        step_req = 1'b0;
        cycles(3, "pause");
        state = 2'b11;
        step_req = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            cycle("pause");
            if (bus0.gen_done === 1'b1) pulses++;
        end
        step_req = 1'b0;
        check("pause pulses", pulses, 1);

        // Reset while evaluating row 4, then a normal step.
        state = 2'b10;
        step_req = 1'b1;
        cycle("midrst");
        step_req = 1'b0;
        cycles(4, "midrst");
        check("midrst sweeping", bus0.busy, 1'b1);
        do_reset("midrst_reset");
        load(64'h0000_0000_1C00_0000, "after_rst");
        step_wait("after_rst");
        check("after_rst shape", bus0.grid, 64'h0000_0008_0808_0000);
        check("after_rst gen_count", bus0.gen_count, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
